sound_synth: RTL and testbench

SOUND_SYNTH -- requirements
Module: sound_synth

---
 rtl/sound_pkg.sv | 36 +++
 rtl/sound_synth_if.sv | 20 ++
 rtl/sound_voice.sv | 93 +++++++++
 rtl/sound_synth.sv | 73 +++++++
 tb/tb_sound_synth.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sound_pkg.sv
// Shared codes for the sound synthesizer: register parameter codes, voice modes,
// noise LFSR definition and the per-voice write request.
package sound_pkg;

    typedef enum logic [2:0] {
        P_PERIOD   = 3'd0,
        P_VOLUME   = 3'd1,
        P_WIDTH    = 3'd2,
        P_MODE     = 3'd3,
        P_ENV_RATE = 3'd4,
        P_TRIGGER  = 3'd5
    } param_e;

    typedef enum logic [1:0] {
        M_OFF    = 2'd0,
        M_SQUARE = 2'd1,
        M_NOISE  = 2'd2,
        M_RSVD   = 2'd3
    } mode_e;

    localparam int              LFSR_W      = 15;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF;
    localparam int              LFSR_TAP_HI = 14;
    localparam int              LFSR_TAP_LO = 13;

    typedef struct packed {
        logic        we;
        logic [2:0]  param;
        logic [15:0] val;
    } voice_wr_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/sound_synth_if.sv
// Register-write bus and mixed-sample outputs of the sound synthesizer.
interface sound_synth_if #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 24
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                wen;
    logic [CH_W-1:0]     ch_sel;
    logic [2:0]          ch_param;
    logic [15:0]         ch_val;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic [NUM_CH-1:0]   active;

    modport master (output wen, ch_sel, ch_param, ch_val,
                    input  sample, sample_valid, active);
    modport slave  (input  wen, ch_sel, ch_param, ch_val,
                    output sample, sample_valid, active);
endinterface

// File: rtl/sound_voice.sv
// One synthesizer voice: config registers, phase counter, square/noise waveform
// and linear decay envelope.
module sound_voice
    import sound_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  voice_wr_t  i_wr,
    output logic       o_level,
    output logic [4:0] o_env_vol,
    output logic       o_active
);
    logic [15:0]       r_period, r_env_rate, r_phase, r_env_cnt;
    logic [4:0]        r_volume, r_env_vol;
    logic [2:0]        r_width;
    mode_e             r_mode;
    logic [LFSR_W-1:0] r_lfsr;

    logic              w_wrap, w_env_tick;
    logic [31:0]       w_phase_x8, w_duty_thr;

    // >= rather than == so shrinking period/env_rate below the live count still wraps
    assign w_wrap     = (r_period != '0) && (r_phase >= r_period - 16'd1);
    assign w_env_tick = (r_env_rate != '0) && (r_env_cnt >= r_env_rate - 16'd1);
    assign w_phase_x8 = {13'd0, r_phase, 3'd0};
    assign w_duty_thr = {16'd0, r_period} * {28'd0, {1'b0, r_width} + 4'd1};

    always_comb begin
        o_level = 1'b0;
        if (r_period != '0) begin
            case (r_mode)
                M_SQUARE: o_level = (w_phase_x8 < w_duty_thr);
                M_NOISE:  o_level = r_lfsr[0];
                default:  o_level = 1'b0;
            endcase
        end
    end

    assign o_env_vol = r_env_vol;
    assign o_active  = ((r_mode == M_SQUARE) || (r_mode == M_NOISE)) && (r_env_vol != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period   <= '0;
            r_env_rate <= '0;
            r_phase    <= '0;
            r_env_cnt  <= '0;
            r_volume   <= '0;
            r_env_vol  <= '0;
            r_width    <= '0;
            r_mode     <= M_OFF;
            r_lfsr     <= LFSR_SEED;
        end else begin
            if (r_period == '0) begin
                r_phase <= '0;
            end else if (w_wrap) begin
                r_phase <= '0;
                r_lfsr  <= lfsr_next(r_lfsr);
            end else begin
                r_phase <= r_phase + 16'd1;
            end

            if (w_env_tick) begin
                r_env_cnt <= '0;
                if (r_env_vol != '0) r_env_vol <= r_env_vol - 5'd1;
            end else if (r_env_rate != '0) begin
                r_env_cnt <= r_env_cnt + 16'd1;
            end

            // Register writes come last so they override the free-running updates above
            if (i_wr.we) begin
                case (i_wr.param)
                    P_PERIOD:   r_period <= i_wr.val;
                    P_VOLUME: begin
                        r_volume  <= i_wr.val[4:0];
                        r_env_vol <= i_wr.val[4:0];
                    end
                    P_WIDTH:    r_width    <= i_wr.val[2:0];
                    P_MODE:     r_mode     <= mode_e'(i_wr.val[1:0]);
                    P_ENV_RATE: r_env_rate <= i_wr.val;
                    P_TRIGGER: begin
                        r_phase   <= '0;
                        r_env_cnt <= '0;
                        r_env_vol <= r_volume;
                        r_lfsr    <= LFSR_SEED;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/sound_synth.sv
// Multi-voice synthesizer: NUM_CH voices summed by a time-multiplexed mixer
// into a saturating unsigned sample once every NUM_CH cycles.
module sound_synth
    import sound_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 24,
    parameter int GAIN_SH  = 17
) (
    input logic         clk,
    input logic         reset,
    sound_synth_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = SAMPLE_W + 4;
    localparam logic [ACC_W-1:0] SAT_MAX = {4'd0, {SAMPLE_W{1'b1}}};

    voice_wr_t [NUM_CH-1:0]           w_wr;
    logic [NUM_CH-1:0]                w_level, w_active;
    logic [NUM_CH-1:0][4:0]           w_env_vol;
    logic [NUM_CH-1:0][ACC_W-1:0]     w_contrib;

    logic [CH_W-1:0]     r_idx;
    logic [ACC_W-1:0]    r_acc, w_sum;
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_valid;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
            // Out-of-range ch_sel never matches a voice; codes 6..7 are dropped here too
            assign w_wr[g] = '{we:    bus.wen && (bus.ch_sel == CH_W'(g)) && (bus.ch_param <= P_TRIGGER),
                               param: bus.ch_param,
                               val:   bus.ch_val};

            sound_voice u_voice (
                .clk       (clk),
                .reset     (reset),
                .i_wr      (w_wr[g]),
                .o_level   (w_level[g]),
                .o_env_vol (w_env_vol[g]),
                .o_active  (w_active[g])
            );

            assign w_contrib[g] = ACC_W'(w_level[g] ? w_env_vol[g] : 5'd0) << GAIN_SH;
        end
    endgenerate

    assign w_sum = ((r_idx == '0) ? '0 : r_acc) + w_contrib[r_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx    <= '0;
            r_acc    <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_acc <= w_sum;
            if (r_idx == CH_W'(NUM_CH - 1)) begin
                r_idx    <= '0;
                r_sample <= (w_sum > SAT_MAX) ? SAT_MAX[SAMPLE_W-1:0] : w_sum[SAMPLE_W-1:0];
                r_valid  <= 1'b1;
            end else begin
                r_idx   <= r_idx + CH_W'(1);
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.sample       = r_sample;
    assign bus.sample_valid = r_valid;
    assign bus.active       = w_active;

endmodule

// File: tb/tb_sound_synth.sv
// Directed bench: expected samples are queued by the stimulus and checked by a
// monitor on each sample_valid; a second instance covers saturation and ch_sel range.
module tb_sound_synth;
    import sound_pkg::*;

    localparam logic [23:0] H = 24'h3E0000;   // 31 << 17

    logic clk, reset;
    int   n_vec, n_err;
    logic [24:0] q[$];
    logic [24:0] mon_e;
    int   env_exp[12] = '{4, 4, 3, 3, 3, 2, 2, 1, 1, 1, 0, 0};
    logic [14:0] lf;

    sound_synth_if #(.NUM_CH(4), .SAMPLE_W(24)) ifA ();
    sound_synth_if #(.NUM_CH(3), .SAMPLE_W(24)) ifB ();

    sound_synth #(.NUM_CH(4), .SAMPLE_W(24), .GAIN_SH(17)) dutA (
        .clk(clk), .reset(reset), .bus(ifA));
    sound_synth #(.NUM_CH(3), .SAMPLE_W(24), .GAIN_SH(19)) dutB (
        .clk(clk), .reset(reset), .bus(ifB));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pushv(input logic [23:0] v);
        q.push_back({1'b1, v});
    endtask

    task automatic pushx();
        q.push_back(25'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && ifA.sample_valid && q.size() > 0) begin
            mon_e = q.pop_front();
            if (mon_e[24]) chk("sampleA", 32'(ifA.sample), 32'(mon_e[23:0]));
        end
    end

    task automatic wrA(input logic [2:0] p, input logic [1:0] c, input logic [15:0] v);
        ifA.wen = 1'b1; ifA.ch_sel = c; ifA.ch_param = p; ifA.ch_val = v;
        @(posedge clk); #1;
        ifA.wen = 1'b0;
    endtask

    task automatic wrB(input logic [2:0] p, input logic [1:0] c, input logic [15:0] v);
        ifB.wen = 1'b1; ifB.ch_sel = c; ifB.ch_param = p; ifB.ch_val = v;
        @(posedge clk); #1;
        ifB.wen = 1'b0;
    endtask

    // Returns just after the edge that raised sample_valid, i.e. mixer index is 0
    task automatic align_a();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(posedge clk); #1;
            ok = ifA.sample_valid;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL alignA: sample_valid not seen within 16 cycles");
        end
    endtask

    task automatic wait_b();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(posedge clk); #1;
            ok = ifB.sample_valid;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL waitB: sample_valid not seen within 16 cycles");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain: %0d expected samples never produced", q.size());
            q.delete();
        end
    endtask

    function automatic logic [14:0] nx(input logic [14:0] l);
        return {l[13:0], l[14] ^ l[13]};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1;
        ifA.wen = 1'b0; ifA.ch_sel = '0; ifA.ch_param = '0; ifA.ch_val = '0;
        ifB.wen = 1'b0; ifB.ch_sel = '0; ifB.ch_param = '0; ifB.ch_val = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sampleA", 32'(ifA.sample), 0);
        chk("rst_validA",  32'(ifA.sample_valid), 0);
        chk("rst_activeA", 32'(ifA.active), 0);
        chk("rst_sampleB", 32'(ifB.sample), 0);
        chk("rst_activeB", 32'(ifB.active), 0);
        reset = 1'b0;

        // period 0 forces level low; param code 6 is ignored
        wrA(P_MODE, 0, 16'd1); wrA(P_WIDTH, 0, 16'd7); wrA(P_VOLUME, 0, 16'd31);
        align_a(); wrA(3'd6, 0, 16'd16);
        pushx(); repeat (3) pushv(24'd0);
        drain();
        chk("activeA_p0", 32'(ifA.active), 32'h1);
        align_a(); wrA(P_PERIOD, 0, 16'd16);
        pushx(); repeat (3) pushv(H);
        drain();

        // square, period 16, width 3: voice sampled every 4 phases -> H H 0 0
        wrA(P_WIDTH, 0, 16'd3);
        align_a(); wrA(P_TRIGGER, 0, 16'd0);
        pushx();
        repeat (2) begin pushv(H); pushv(H); pushv(0); pushv(0); end
        drain();

        // envelope decay 4..0 every 10 cycles
        wrA(P_WIDTH, 0, 16'd7); wrA(P_ENV_RATE, 0, 16'd10); wrA(P_VOLUME, 0, 16'd4);
        align_a(); wrA(P_TRIGGER, 0, 16'd0);
        chk("activeA_env_start", 32'(ifA.active), 32'h1);
        pushx();
        for (int i = 0; i < 12; i++) pushv(24'(env_exp[i]) << 17);
        drain();
        chk("activeA_env_end", 32'(ifA.active), 32'h0);

        // volume write lands on the decrement edge: the write value wins
        wrA(P_VOLUME, 0, 16'd4);
        align_a(); wrA(P_TRIGGER, 0, 16'd0);
        pushx(); pushv(24'h080000); pushv(24'h080000);
        pushv(24'h280000); pushv(24'h280000); pushv(24'h280000);
        repeat (9) @(posedge clk);
        #1;
        wrA(P_VOLUME, 0, 16'd20);
        drain();

        // noise, period 1: LFSR steps every cycle, voice seen every 4th step
        wrA(P_ENV_RATE, 0, 16'd0); wrA(P_VOLUME, 0, 16'd31);
        wrA(P_MODE, 0, 16'd2); wrA(P_PERIOD, 0, 16'd1);
        align_a(); wrA(P_TRIGGER, 0, 16'd0);
        pushx();
        lf = 15'h7FFF;
        for (int j = 0; j < 25; j++) begin
            for (int k = 0; k < ((j == 0) ? 3 : 4); k++) lf = nx(lf);
            pushv(lf[0] ? H : 24'd0);
        end
        drain();

        // async reset mid-sweep with a write pending
        chk("activeA_pre_rst", 32'(ifA.active), 32'h1);
        ifA.wen = 1'b1; ifA.ch_sel = 2'd0; ifA.ch_param = P_VOLUME; ifA.ch_val = 16'd5;
        #2;
        reset = 1'b1;
        #1;
        chk("async_sampleA", 32'(ifA.sample), 0);
        chk("async_validA",  32'(ifA.sample_valid), 0);
        chk("async_activeA", 32'(ifA.active), 0);
        ifA.wen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            chk("validA_after_rst", 32'(ifA.sample_valid), (e == 4) ? 32'h1 : 32'h0);
        end
        repeat (3) pushv(24'd0);
        drain();
        chk("activeA_after_rst", 32'(ifA.active), 32'h0);

        // instance B: GAIN_SH 19, 3 voices
        wrB(P_PERIOD, 0, 16'd16); wrB(P_WIDTH, 0, 16'd7);
        wrB(P_MODE, 0, 16'd1);    wrB(P_VOLUME, 0, 16'd31);
        repeat (3) wait_b();
        chk("sampleB_one", 32'(ifB.sample), 32'hF80000);
        wrB(P_VOLUME, 3, 16'd31); wrB(P_MODE, 3, 16'd1);
        wrB(P_PERIOD, 3, 16'd16); wrB(P_WIDTH, 3, 16'd7);
        wrB(3'd7, 0, 16'd0);
        repeat (3) wait_b();
        chk("sampleB_oob", 32'(ifB.sample), 32'hF80000);
        chk("activeB_oob", 32'(ifB.active), 32'h1);
        for (int c = 1; c <= 2; c++) begin
            wrB(P_PERIOD, 2'(c), 16'd16); wrB(P_WIDTH, 2'(c), 16'd7);
            wrB(P_MODE, 2'(c), 16'd1);    wrB(P_VOLUME, 2'(c), 16'd31);
        end
        repeat (3) wait_b();
        chk("sampleB_sat", 32'(ifB.sample), 32'hFFFFFF);
        chk("activeB_all", 32'(ifB.active), 32'h7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
